// File: rtl/systolic_array_ctrl_if.sv
// Host command / result-handshake and array control bundle for the systolic array sequencer.
interface systolic_array_ctrl_if #(
   parameter int unsigned ARRAY_SIZE = 4,
   parameter int unsigned K_MAX      = 256
);
   localparam int unsigned KW = $clog2(K_MAX) + 1;
   localparam int unsigned CW = $clog2(K_MAX + 2 * ARRAY_SIZE);
   localparam int unsigned RW = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;

   logic                  start;
   logic [KW-1:0]         k_len;
   logic                  busy;
   logic                  arr_clr;
   logic                  arr_enb;
   logic [CW-1:0]         feed_cnt;
   logic [ARRAY_SIZE-1:0] lane_vld;
   logic                  out_valid;
   logic                  out_ready;
   logic [RW-1:0]         rd_row;
   logic                  done;

   // Host / array side: issues commands, consumes result rows.
   modport master (
      output start, k_len, out_ready,
      input  busy, arr_clr, arr_enb, feed_cnt, lane_vld, out_valid, rd_row, done
   );

   // Sequencer side.
   modport slave (
      input  start, k_len, out_ready,
      output busy, arr_clr, arr_enb, feed_cnt, lane_vld, out_valid, rd_row, done
   );
endinterface

// File: rtl/systolic_array_ctrl.sv
// Sequencer for an N x N output-stationary MAC array: clear, skewed feed, drain,
// row-by-row readout over valid/ready, then a one-cycle done pulse.
module systolic_array_ctrl #(
   parameter int unsigned ARRAY_SIZE = 4,
   parameter int unsigned K_MAX      = 256
) (
   input  logic                 clk,
   input  logic                 rst,
   systolic_array_ctrl_if.slave bus
);
   localparam int unsigned N  = ARRAY_SIZE;
   localparam int unsigned KW = $clog2(K_MAX) + 1;
   localparam int unsigned CW = $clog2(K_MAX + 2 * ARRAY_SIZE);
   localparam int unsigned RW = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;
   // Compare width: holds kl + 2N without wrap.
   localparam int unsigned XW = ((KW > CW) ? KW : CW) + 1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLEAR = 3'd1,
      S_FEED  = 3'd2,
      S_DRAIN = 3'd3,
      S_READ  = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t        state, state_nxt;
   logic [KW-1:0] kl, kl_nxt;
   logic [CW-1:0] t, t_nxt;
   logic [RW-1:0] rd, rd_nxt;

   logic          feed_last;
   logic          drain_last;
   logic          row_last;

   logic          busy_nxt;
   logic          clr_nxt;
   logic          enb_nxt;
   logic [CW-1:0] feed_nxt;
   logic [N-1:0]  lane_nxt;
   logic          valid_nxt;
   logic [RW-1:0] row_nxt;
   logic          done_nxt;

   assign feed_last  = (XW'(t) == XW'(kl) + XW'(N) - XW'(2));
   assign drain_last = (XW'(t) == XW'(kl) + XW'(2 * N) - XW'(3));
   assign row_last   = (rd == RW'(N - 1));

   // State, counters and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= S_IDLE;
         kl            <= '0;
         t             <= '0;
         rd            <= '0;
         bus.busy      <= 1'b0;
         bus.arr_clr   <= 1'b0;
         bus.arr_enb   <= 1'b0;
         bus.feed_cnt  <= '0;
         bus.lane_vld  <= '0;
         bus.out_valid <= 1'b0;
         bus.rd_row    <= '0;
         bus.done      <= 1'b0;
      end else begin
         state         <= state_nxt;
         kl            <= kl_nxt;
         t             <= t_nxt;
         rd            <= rd_nxt;
         bus.busy      <= busy_nxt;
         bus.arr_clr   <= clr_nxt;
         bus.arr_enb   <= enb_nxt;
         bus.feed_cnt  <= feed_nxt;
         bus.lane_vld  <= lane_nxt;
         bus.out_valid <= valid_nxt;
         bus.rd_row    <= row_nxt;
         bus.done      <= done_nxt;
      end
   end

   // Next state and counter updates.
   always_comb begin
      state_nxt = state;
      kl_nxt    = kl;
      t_nxt     = t;
      rd_nxt    = rd;
      unique case (state)
         S_IDLE: begin
            t_nxt  = '0;
            rd_nxt = '0;
            if (bus.start && (bus.k_len != '0)) begin
               state_nxt = S_CLEAR;
               kl_nxt    = bus.k_len;
            end
         end
         S_CLEAR: begin
            state_nxt = S_FEED;
            t_nxt     = '0;
         end
         S_FEED: begin
            if (feed_last) begin
               // A 1x1 array has no skew to drain.
               state_nxt = (N == 1) ? S_READ : S_DRAIN;
               t_nxt     = (N == 1) ? '0 : t + CW'(1);
            end else begin
               t_nxt = t + CW'(1);
            end
         end
         S_DRAIN: begin
            if (drain_last) begin
               state_nxt = S_READ;
               t_nxt     = '0;
            end else begin
               t_nxt = t + CW'(1);
            end
         end
         S_READ: begin
            if (bus.out_ready) begin
               if (row_last) begin
                  state_nxt = S_DONE;
                  rd_nxt    = '0;
               end else begin
                  rd_nxt = rd + RW'(1);
               end
            end
         end
         S_DONE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Output decode from next state/counters so the registered outputs line up with the state.
   always_comb begin
      busy_nxt  = (state_nxt != S_IDLE);
      clr_nxt   = (state_nxt == S_CLEAR);
      enb_nxt   = (state_nxt == S_FEED) || (state_nxt == S_DRAIN);
      feed_nxt  = enb_nxt ? t_nxt : '0;
      valid_nxt = (state_nxt == S_READ);
      row_nxt   = valid_nxt ? rd_nxt : '0;
      done_nxt  = (state_nxt == S_DONE);
      lane_nxt  = '0;
      for (int unsigned i = 0; i < N; i++) begin
         lane_nxt[i] = (state_nxt == S_FEED)
                       && (XW'(t_nxt) >= XW'(i))
                       && (XW'(t_nxt) <  XW'(i) + XW'(kl_nxt));
      end
   end

endmodule
